// File: rtl/nvram_pkg.sv
// Shared constants and state encoding for the EAROM NVRAM port.
// Imported by the shadow RAM and the HPS-facing responder.
package nvram_pkg;

    localparam int NV_ADDR_W = 6;
    localparam int NV_DEPTH = 2 ** NV_ADDR_W;
    localparam logic [7:0] NV_INDEX_DFLT = 8'd4;
    localparam logic [7:0] OOR_DATA = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        PEND_RD,
        RESP,
        PEND_WR
    } nv_state_e;

endpackage

// File: rtl/nvram_sp.sv
// Single-port byte RAM with registered read; contents survive reset.
// Shadows the game's EAROM so HPS can save and restore it.
module nvram_sp
    import nvram_pkg::*;
#(
    parameter int ADDR_W = NV_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] mem [2**ADDR_W];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/earom_nvram_port.sv
// HPS NVRAM upload/download responder sharing the EAROM shadow RAM
// with the game CPU; the CPU always owns the RAM when it accesses it.
module earom_nvram_port
    import nvram_pkg::*;
#(
    parameter int         ADDR_W   = NV_ADDR_W,
    parameter logic [7:0] NV_INDEX = NV_INDEX_DFLT
) (
    input  logic              clk_12,
    input  logic              reset,
    input  logic              ioctl_upload,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic [24:0]       ioctl_addr,
    input  logic              ioctl_rd,
    input  logic              ioctl_wr,
    input  logic [7:0]        ioctl_dout,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    input  logic              cpu_we,
    input  logic              cpu_re,
    output logic [7:0]        cpu_dout,
    output logic              nv_dirty,
    output logic              nv_loaded
);

    nv_state_e state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic oor_q, oor_d;
    logic wait_q, wait_d;
    logic [7:0] din_q, din_d;
    logic cpu_rd_q, cpu_rd_d;
    logic [7:0] cpu_hold_q, cpu_hold_d;
    logic dirty_q, dirty_d;
    logic loaded_q, loaded_d;
    logic up_prev_q, up_prev_d;
    logic dn_prev_q, dn_prev_d;
    logic last_q, last_d;
    logic sess_we_q, sess_we_d;

    logic sel, rd_req, wr_req, oor, cpu_acc;
    logic up_rise, up_fall, dn_fall;
    logic ram_we, ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0] ram_wdata, ram_q;

    assign sel = (ioctl_index == NV_INDEX);
    assign rd_req = ioctl_rd & ioctl_upload & sel;
    assign wr_req = ioctl_wr & ioctl_download & sel;
    assign oor = (ioctl_addr[24:ADDR_W] != '0);
    assign cpu_acc = cpu_we | cpu_re;
    assign up_rise = ioctl_upload & ~up_prev_q;
    assign up_fall = up_prev_q & ~ioctl_upload & sel;
    assign dn_fall = dn_prev_q & ~ioctl_download & sel;

    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        data_d = data_q;
        oor_d = oor_q;
        wait_d = wait_q;
        din_d = din_q;
        dirty_d = dirty_q;
        loaded_d = loaded_q;
        last_d = last_q;
        sess_we_d = sess_we_q;
        up_prev_d = ioctl_upload;
        dn_prev_d = ioctl_download;
        cpu_rd_d = cpu_re & ~cpu_we;
        cpu_hold_d = cpu_rd_q ? ram_q : cpu_hold_q;
        ram_addr = cpu_addr;
        ram_wdata = cpu_din;
        ram_we = cpu_we;
        ram_re = cpu_re & ~cpu_we;

        unique case (state_q)
            IDLE: begin
                if (rd_req) begin
                    addr_d = ioctl_addr[ADDR_W-1:0];
                    oor_d = oor;
                    wait_d = 1'b1;
                    state_d = PEND_RD;
                end else if (wr_req) begin
                    addr_d = ioctl_addr[ADDR_W-1:0];
                    data_d = ioctl_dout;
                    oor_d = oor;
                    wait_d = 1'b1;
                    state_d = PEND_WR;
                end
            end
            PEND_RD: begin
                if (!cpu_acc) begin
                    ram_addr = addr_q;
                    ram_re = ~oor_q;
                    state_d = RESP;
                end
            end
            RESP: begin
                din_d = oor_q ? OOR_DATA : ram_q;
                wait_d = 1'b0;
                state_d = IDLE;
                if (!oor_q && addr_q == '1) begin
                    last_d = 1'b1;
                end
            end
            PEND_WR: begin
                if (!cpu_acc) begin
                    ram_addr = addr_q;
                    ram_wdata = data_q;
                    ram_we = ~oor_q;
                    wait_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A clean upload needs the whole image read with no CPU edits.
        if (up_rise) begin
            last_d = 1'b0;
            sess_we_d = 1'b0;
        end
        if (cpu_we) begin
            sess_we_d = 1'b1;
        end
        if (up_fall && last_q && !sess_we_q && !cpu_we) begin
            dirty_d = 1'b0;
        end
        if (dn_fall) begin
            loaded_d = 1'b1;
            if (!cpu_we) begin
                dirty_d = 1'b0;
            end
        end
        if (cpu_we) begin
            dirty_d = 1'b1;
        end
    end

    always_ff @(posedge clk_12) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q <= '0;
            data_q <= '0;
            oor_q <= 1'b0;
            wait_q <= 1'b0;
            din_q <= '0;
            cpu_rd_q <= 1'b0;
            cpu_hold_q <= '0;
            dirty_q <= 1'b0;
            loaded_q <= 1'b0;
            up_prev_q <= 1'b0;
            dn_prev_q <= 1'b0;
            last_q <= 1'b0;
            sess_we_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            data_q <= data_d;
            oor_q <= oor_d;
            wait_q <= wait_d;
            din_q <= din_d;
            cpu_rd_q <= cpu_rd_d;
            cpu_hold_q <= cpu_hold_d;
            dirty_q <= dirty_d;
            loaded_q <= loaded_d;
            up_prev_q <= up_prev_d;
            dn_prev_q <= dn_prev_d;
            last_q <= last_d;
            sess_we_q <= sess_we_d;
        end
    end

    nvram_sp #(
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk_12),
        .we   (ram_we),
        .re   (ram_re),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_q)
    );

    assign ioctl_din = din_q;
    assign ioctl_wait = wait_q;
    assign cpu_dout = cpu_rd_q ? ram_q : cpu_hold_q;
    assign nv_dirty = dirty_q;
    assign nv_loaded = loaded_q;

endmodule
